// File: rtl/m65c02_lst_pkg.sv
// Shared constants, FSM encoding and transfer payload for the M65C02A LST sequencer.
package m65c02_lst_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned PFX_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OVR_W  = 3;
  localparam int unsigned STAT_W = 16;

  localparam logic [SEL_W-1:0] OSEL_NONE = 3'd0;
  localparam logic [SEL_W-1:0] OSEL_X    = 3'd1;
  localparam logic [SEL_W-1:0] OSEL_Y    = 3'd2;
  localparam logic [SEL_W-1:0] OSEL_A    = 3'd3;
  localparam logic [SEL_W-1:0] OSEL_T    = 3'd4;
  localparam logic [SEL_W-1:0] OSEL_S    = 3'd5;
  localparam logic [SEL_W-1:0] OSEL_P    = 3'd6;
  localparam logic [SEL_W-1:0] OSEL_M    = 3'd7;

  localparam logic [PFX_W-1:0] PFX_NONE = 2'd0;
  localparam logic [PFX_W-1:0] PFX_OAX  = 2'd1;
  localparam logic [PFX_W-1:0] PFX_OAY  = 2'd2;
  localparam logic [PFX_W-1:0] PFX_OSY  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PFX  = 2'd1,
    ST_ACT  = 2'd2
  } lst_state_e;

  typedef struct packed {
    logic             en;
    logic [SEL_W-1:0] sel;
  } lst_xfr_t;

  // One-hot override vector ordered {OAX, OAY, OSY}.
  function automatic logic [OVR_W-1:0] pfx_to_ovr(input logic [PFX_W-1:0] sel);
    logic [OVR_W-1:0] ovr;
    ovr = '0;
    case (sel)
      PFX_OAX: ovr = 3'b100;
      PFX_OAY: ovr = 3'b010;
      PFX_OSY: ovr = 3'b001;
      default: ovr = '0;
    endcase
    return ovr;
  endfunction

endpackage

// File: rtl/m65c02_pfx_tracker.sv
// Prefix tracker: IDLE/PFX/ACT sequencing, one-hot override, chain count and overflow pulse.
module m65c02_pfx_tracker
  import m65c02_lst_pkg::*;
#(
  parameter int unsigned MAX_PFX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             pfx_vld,
  input  logic [PFX_W-1:0] pfx_sel,
  input  logic             op_vld,
  input  logic             done,
  output logic [OVR_W-1:0] ovr_act_c,
  output logic             int_inh,
  output logic             pfx_err
);

  lst_state_e       state, state_nxt;
  logic [OVR_W-1:0] ovr, ovr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             pfx_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ovr     <= '0;
      cnt     <= '0;
      pfx_err <= 1'b0;
      int_inh <= 1'b0;
    end else begin
      state   <= state_nxt;
      ovr     <= ovr_nxt;
      cnt     <= cnt_nxt;
      pfx_err <= err_nxt;
      int_inh <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    ovr_nxt   = ovr;
    cnt_nxt   = cnt;
    err_nxt   = pfx_err;
    pfx_c     = pfx_vld && (pfx_sel != PFX_NONE);
    if (rdy) begin
      err_nxt = 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pfx_c) begin
            state_nxt = ST_PFX;
            ovr_nxt   = pfx_to_ovr(pfx_sel);
            cnt_nxt   = CNT_W'(1);
          end
        end
        ST_PFX: begin
          // A prefix arriving with the chain already full aborts the chain.
          if (pfx_c) begin
            if (cnt == CNT_W'(MAX_PFX)) begin
              state_nxt = ST_IDLE;
              ovr_nxt   = '0;
              cnt_nxt   = '0;
              err_nxt   = 1'b1;
            end else begin
              ovr_nxt = pfx_to_ovr(pfx_sel);
              cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            end
          end else if (op_vld) begin
            state_nxt = ST_ACT;
          end
        end
        ST_ACT: begin
          if (done) begin
            if (pfx_c) begin
              state_nxt = ST_PFX;
              ovr_nxt   = pfx_to_ovr(pfx_sel);
              cnt_nxt   = CNT_W'(1);
            end else begin
              state_nxt = ST_IDLE;
              ovr_nxt   = '0;
              cnt_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          ovr_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
    ovr_act_c = (state_nxt == ST_ACT) ? ovr_nxt : '0;
  end

endmodule

// File: rtl/m65c02_lst_ctrl.sv
// M65C02A LST sequencer top: prefix tracker, registered transfer pipe and override outputs.
// Optional M65C02A_LST_STATS_EN adds ovr_cnt, a count of overridden transfers.
module m65c02_lst_ctrl
  import m65c02_lst_pkg::*;
#(
  parameter int unsigned MAX_PFX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              pfx_vld,
  input  logic [PFX_W-1:0]  pfx_sel,
  input  logic              op_vld,
  input  logic              done,
  input  logic              xfr_req,
  input  logic [SEL_W-1:0]  xfr_sel,
  output logic              en,
  output logic [SEL_W-1:0]  osel,
  output logic              oax,
  output logic              oay,
  output logic              osy,
  output logic              int_inh,
  output logic              pfx_err
`ifdef M65C02A_LST_STATS_EN
  ,
  output logic [STAT_W-1:0] ovr_cnt
`endif
);

  logic [OVR_W-1:0] ovr_act_c;
  lst_xfr_t         xfr_d;

  m65c02_pfx_tracker #(
    .MAX_PFX (MAX_PFX)
  ) u_pfx_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .pfx_vld   (pfx_vld),
    .pfx_sel   (pfx_sel),
    .op_vld    (op_vld),
    .done      (done),
    .ovr_act_c (ovr_act_c),
    .int_inh   (int_inh),
    .pfx_err   (pfx_err)
  );

  // Transfer request for the next cycle; select holds when no transfer is issued.
  always_comb begin
    xfr_d.en  = en;
    xfr_d.sel = osel;
    if (rdy) begin
      xfr_d.en = xfr_req && (xfr_sel != OSEL_NONE);
      if (xfr_d.en) begin
        xfr_d.sel = xfr_sel;
      end
    end
  end

  // Overrides and transfer pipe share an edge so first-ACT-cycle transfers see the override.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en   <= 1'b0;
      osel <= OSEL_NONE;
      oax  <= 1'b0;
      oay  <= 1'b0;
      osy  <= 1'b0;
    end else begin
      en   <= xfr_d.en;
      osel <= xfr_d.sel;
      oax  <= ovr_act_c[2];
      oay  <= ovr_act_c[1];
      osy  <= ovr_act_c[0];
    end
  end

`ifdef M65C02A_LST_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (rdy && xfr_d.en && (ovr_act_c != '0)) begin
      ovr_cnt <= ovr_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
